// File: rtl/sram_arbiter_if.sv
// Bundle between the pipeline fetch/mem ports, the arbiter and the single-ported SRAM.
// The arbiter uses the slave view; the pipeline-plus-SRAM side uses the master view.
interface sram_arbiter_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WEN_W  = 4;

   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_gnt;
   logic              inst_valid;
   logic [DATA_W-1:0] inst_rdata;

   logic              data_req;
   logic [WEN_W-1:0]  data_wen;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_gnt;
   logic              data_valid;
   logic [DATA_W-1:0] data_rdata;

   logic              ram_en;
   logic [WEN_W-1:0]  ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, ram_rdata,
      output inst_gnt, inst_valid, inst_rdata, data_gnt, data_valid, data_rdata,
      output ram_en, ram_wen, ram_addr, ram_wdata
   );

   modport master (
      output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, ram_rdata,
      input  inst_gnt, inst_valid, inst_rdata, data_gnt, data_valid, data_rdata,
      input  ram_en, ram_wen, ram_addr, ram_wdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one synchronous SRAM between instruction fetch and data access: data has
// priority, a starvation counter bounds how long fetch waits, responses return one cycle later.
module sram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           resetn,
   sram_arbiter_if.slave bus
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WEN_W  = 4;

   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_INST,
      RESP_DATA_RD,
      RESP_DATA_WR
   } respSrc_t;

   respSrc_t          respSrc;
   respSrc_t          respSrcNext;
   logic [CNT_W-1:0]  starveCnt;
   logic [CNT_W-1:0]  starveCntNext;
   logic [DATA_W-1:0] instHold;
   logic [DATA_W-1:0] dataHold;
   logic              instGnt;
   logic              dataGnt;
   logic              starved;

   // kseg0/kseg1 fold onto physical address zero; everything else is identity mapped.
   function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] vaddr);
      logic [ADDR_W-1:0] paddr;
      paddr = vaddr;
      if (vaddr[31:29] == 3'b100 || vaddr[31:29] == 3'b101) begin
         paddr[31:29] = 3'b000;
      end
      return paddr;
   endfunction

   // Arbitration, SRAM command steering and next-state selection.
   always_comb begin
      starved       = 1'b0;
      instGnt       = 1'b0;
      dataGnt       = 1'b0;
      respSrcNext   = RESP_NONE;
      starveCntNext = '0;
      bus.ram_en    = 1'b0;
      bus.ram_wen   = '0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;

      starved = (starveCnt >= CNT_W'(STARVE_LIMIT));
      instGnt = resetn & bus.inst_req & (~bus.data_req | starved);
      dataGnt = resetn & bus.data_req & ~instGnt;

      if (dataGnt) begin
         bus.ram_en    = 1'b1;
         bus.ram_wen   = bus.data_wen;
         bus.ram_addr  = xlate(bus.data_addr);
         bus.ram_wdata = bus.data_wdata;
         respSrcNext   = (bus.data_wen == WEN_W'(0)) ? RESP_DATA_RD : RESP_DATA_WR;
      end else if (instGnt) begin
         bus.ram_en    = 1'b1;
         bus.ram_addr  = xlate(bus.inst_addr);
         respSrcNext   = RESP_INST;
      end

      // Count only cycles where fetch is actually waiting; saturate at the limit.
      if (bus.inst_req && !instGnt) begin
         starveCntNext = starved ? starveCnt : starveCnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         respSrc   <= RESP_NONE;
         starveCnt <= '0;
         instHold  <= '0;
         dataHold  <= '0;
      end else begin
         respSrc   <= respSrcNext;
         starveCnt <= starveCntNext;
         if (respSrc == RESP_INST) begin
            instHold <= bus.ram_rdata;
         end
         if (respSrc == RESP_DATA_RD) begin
            dataHold <= bus.ram_rdata;
         end
      end
   end

   assign bus.inst_gnt   = instGnt;
   assign bus.data_gnt   = dataGnt;
   assign bus.inst_valid = (respSrc == RESP_INST);
   assign bus.data_valid = (respSrc == RESP_DATA_RD) || (respSrc == RESP_DATA_WR);
   assign bus.inst_rdata = (respSrc == RESP_INST) ? bus.ram_rdata : instHold;
   assign bus.data_rdata = (respSrc == RESP_DATA_RD) ? bus.ram_rdata : dataHold;
endmodule
